int8_mac_seq: RTL and testbench

//   Sequencer for the combinational 33-lane INT8 MAC datapath. It accepts a job of
//   N operand blocks over a valid/ready stream and feeds one block per cycle to the MAC.
//   It chains the 24-bit partial sum through its accumulator register.

---
 rtl/int8_mac_seq_pkg.sv | 17 +
 rtl/int8_mac_seq.sv | 146 ++++++++++++++
 tb/tb_int8_mac_seq.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/int8_mac_seq_pkg.sv
// Shared constants and state encoding for the INT8 MAC sequencer.
// Byte 0 of each operand vector carries the block scale; bytes 1..32 are MAC operands.
package int8_mac_seq_pkg;

    localparam int BYTE_W    = 8;
    localparam int LANES     = 33;
    localparam int VEC_W     = LANES * BYTE_W;
    localparam int PSUM_W    = 24;
    localparam int SCALE_IDX = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/int8_mac_seq.sv
// Job sequencer for the external 33-lane INT8 MAC: streams N blocks into the MAC,
// chains the 24-bit partial sum and returns the final sum with the block-0 scales.
module int8_mac_seq
    import int8_mac_seq_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_num_blk,
    output logic              busy,
    output logic              err_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [VEC_W-1:0]  in_a,
    input  logic [VEC_W-1:0]  in_b,
    output logic              mac_en,
    output logic [VEC_W-1:0]  mac_a_vec,
    output logic [VEC_W-1:0]  mac_b_vec,
    output logic [PSUM_W-1:0] mac_psum_in,
    input  logic [PSUM_W-1:0] mac_psum_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PSUM_W-1:0] out_sum,
    output logic [BYTE_W-1:0] out_scale_a,
    output logic [BYTE_W-1:0] out_scale_b
);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    num_q, num_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PSUM_W-1:0]   acc_q, acc_d;
    logic                out_valid_q, out_valid_d;
    logic [PSUM_W-1:0]   out_sum_q, out_sum_d;
    logic [BYTE_W-1:0]   scale_a_q, scale_a_d;
    logic [BYTE_W-1:0]   scale_b_q, scale_b_d;
    logic                err_len_q, err_len_d;

    logic in_accum;
    logic in_hs;
    logic last_blk;

    assign in_accum = (state_q == ACCUM);
    assign in_hs    = in_accum && in_valid;
    assign last_blk = (cnt_q == num_q - CNT_W'(1));

    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        scale_a_d   = scale_a_q;
        scale_b_d   = scale_b_q;
        err_len_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_num_blk != '0) begin
                        num_d   = cfg_num_blk;
                        cnt_d   = '0;
                        acc_d   = '0;
                        state_d = ACCUM;
                    end else begin
                        err_len_d = 1'b1;
                    end
                end
            end
            ACCUM: begin
                if (in_hs) begin
                    acc_d = mac_psum_out;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == '0) begin
                        scale_a_d = in_a[SCALE_IDX*BYTE_W +: BYTE_W];
                        scale_b_d = in_b[SCALE_IDX*BYTE_W +: BYTE_W];
                    end
                    if (last_blk) begin
                        out_sum_d   = mac_psum_out;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                // Result, sum and scales stay frozen until the consumer takes them.
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Soft abort overrides every other event, including a same-cycle start.
        if (clr) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            acc_d       = '0;
            cnt_d       = '0;
            err_len_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            num_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            scale_a_q   <= '0;
            scale_b_q   <= '0;
            err_len_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            scale_a_q   <= scale_a_d;
            scale_b_q   <= scale_b_d;
            err_len_q   <= err_len_d;
        end
    end

    // MAC inputs are forced to zero outside ACCUM so the datapath stays quiet.
    assign mac_en      = in_accum && (cnt_q != '0);
    assign mac_a_vec   = in_accum ? in_a  : '0;
    assign mac_b_vec   = in_accum ? in_b  : '0;
    assign mac_psum_in = in_accum ? acc_q : '0;

    assign in_ready    = in_accum;
    assign busy        = (state_q != IDLE);
    assign err_len     = err_len_q;
    assign out_valid   = out_valid_q;
    assign out_sum     = out_sum_q;
    assign out_scale_a = scale_a_q;
    assign out_scale_b = scale_b_q;

endmodule

// File: tb/tb_int8_mac_seq.sv
// Scoreboard bench for int8_mac_seq with a behavioural unsigned INT8 MAC on the mac_* ports.
module tb_int8_mac_seq;

    localparam int CNT_W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clr = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   cfg_num_blk = '0;
    logic         busy, err_len;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [263:0] in_a = '0;
    logic [263:0] in_b = '0;
    logic         mac_en;
    logic [263:0] mac_a_vec, mac_b_vec;
    logic [23:0]  mac_psum_in, mac_psum_out;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [23:0]  out_sum;
    logic [7:0]   out_scale_a, out_scale_b;

    typedef struct {
        logic [23:0] sum;
        logic [7:0]  sa;
        logic [7:0]  sb;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int8_mac_seq #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .cfg_num_blk(cfg_num_blk),
        .busy(busy), .err_len(err_len), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .mac_en(mac_en), .mac_a_vec(mac_a_vec),
        .mac_b_vec(mac_b_vec), .mac_psum_in(mac_psum_in), .mac_psum_out(mac_psum_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_scale_a(out_scale_a), .out_scale_b(out_scale_b)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] mac_model(input logic en, input logic [23:0] p,
                                              input logic [263:0] a, input logic [263:0] b);
        logic [23:0] s, pa, pb;
        s = en ? p : 24'd0;
        for (int i = 1; i < 33; i++) begin
            pa = 24'(a[i*8 +: 8]);
            pb = 24'(b[i*8 +: 8]);
            s  = s + pa * pb;
        end
        return s;
    endfunction

    always_comb mac_psum_out = mac_model(mac_en, mac_psum_in, mac_a_vec, mac_b_vec);

    function automatic logic [263:0] fill(input logic [7:0] scale, input logic [7:0] val);
        logic [263:0] v;
        v = {33{val}};
        v[7:0] = scale;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every result handshake is matched against the oldest expected entry.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got sum %0d, expected no result", out_sum);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_sum", 32'(out_sum), 32'(e.sum));
                    chk("out_scale_a", 32'(out_scale_a), 32'(e.sa));
                    chk("out_scale_b", 32'(out_scale_b), 32'(e.sb));
                end
            end
        end
    end

    task automatic job_start(input logic [7:0] n);
        start = 1'b1;
        cfg_num_blk = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_block(input logic [263:0] a, input logic [263:0] b,
                              input int gap, input logic exp_en);
        int n;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        chk("in_ready", 32'(in_ready), 32'd1);
        chk("mac_en", 32'(mac_en), 32'(exp_en));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 50) begin @(posedge clk); #1; n++; end
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_mac_en"}, 32'(mac_en), 32'd0);
        chk({tag, "_mac_psum_in"}, 32'(mac_psum_in), 32'd0);
    endtask

    task automatic job1();
        exp_q.push_back('{sum: 24'd64, sa: 8'h11, sb: 8'h22});
        job_start(8'd1);
        send_block(fill(8'h11, 8'h01), fill(8'h22, 8'h02), 0, 1'b0);
        chk("t1_latency_out_valid", 32'(out_valid), 32'd1);
    endtask

    initial begin
        int n;
        // Reset state
        #2;
        chk_quiet("reset");
        chk("reset_out_sum", 32'(out_sum), 32'd0);
        chk("reset_err_len", 32'(err_len), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: single block
        job1();
        wait_idle();

        // 2: four 0xFF blocks with input gaps; mac_en low only on block 0
        exp_q.push_back('{sum: 24'd8323200, sa: 8'hFF, sb: 8'hFF});
        job_start(8'd4);
        send_block(fill(8'hFF, 8'hFF), fill(8'hFF, 8'hFF), 1, 1'b0);
        send_block(fill(8'hFF, 8'hFF), fill(8'hFF, 8'hFF), 3, 1'b1);
        send_block(fill(8'hFF, 8'hFF), fill(8'hFF, 8'hFF), 2, 1'b1);
        send_block(fill(8'hFF, 8'hFF), fill(8'hFF, 8'hFF), 1, 1'b1);
        chk("t2_out_valid", 32'(out_valid), 32'd1);
        wait_idle();

        // 3: nine 0xFF blocks, accumulator wraps mod 2^24
        exp_q.push_back('{sum: 24'd1949984, sa: 8'hFF, sb: 8'hFF});
        job_start(8'd9);
        for (int i = 0; i < 9; i++)
            send_block(fill(8'hFF, 8'hFF), fill(8'hFF, 8'hFF), 0, (i != 0));
        wait_idle();

        // 4: back-pressure on the result; start pulses ignored while DONE
        out_ready = 1'b0;
        job1();
        for (int i = 0; i < 5; i++) begin
            chk("t4_out_valid_hold", 32'(out_valid), 32'd1);
            chk("t4_out_sum_hold", 32'(out_sum), 32'd64);
            chk("t4_in_ready", 32'(in_ready), 32'd0);
            chk("t4_busy", 32'(busy), 32'd1);
            start = (i % 2 == 0);
            cfg_num_blk = 8'd3;
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("t4_still_done", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t4_post_busy", 32'(busy), 32'd0);
        chk("t4_post_out_valid", 32'(out_valid), 32'd0);

        // 5: zero-length job
        start = 1'b1;
        cfg_num_blk = 8'd0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("t5_err_len", 32'(err_len), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("t5_err_len_drop", 32'(err_len), 32'd0);
        chk("t5_busy_after", 32'(busy), 32'd0);

        // 6a: async reset mid-job
        job_start(8'd4);
        send_block(fill(8'h05, 8'h03), fill(8'h06, 8'h04), 0, 1'b0);
        send_block(fill(8'h05, 8'h03), fill(8'h06, 8'h04), 0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_quiet("t6_rst");
        chk("t6_rst_out_sum", 32'(out_sum), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        job1();
        wait_idle();

        // 6b: clr mid-job, then clr together with start
        job_start(8'd4);
        send_block(fill(8'h07, 8'h09), fill(8'h08, 8'h0A), 0, 1'b0);
        send_block(fill(8'h07, 8'h09), fill(8'h08, 8'h0A), 0, 1'b1);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk_quiet("t6_clr");
        clr = 1'b1;
        start = 1'b1;
        cfg_num_blk = 8'd1;
        @(posedge clk); #1;
        clr = 1'b0;
        start = 1'b0;
        chk("t6_clr_start_busy", 32'(busy), 32'd0);
        job1();
        wait_idle();

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
